// File: rtl/ula_issue_unit.sv
// Issue stage in front of the ula: accepts commands, evaluates ARM-style conditions
// against a sticky NZCV register, captures the ula result and returns it as a response.
module ula_issue_unit #(
  parameter int ULA_BITS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ULA_BITS-1:0] cmd_a,
  input  logic [ULA_BITS-1:0] cmd_b,
  input  logic [2:0]          cmd_op,
  input  logic                cmd_setf,
  input  logic [3:0]          cmd_cond,
  output logic [ULA_BITS-1:0] ula_a,
  output logic [ULA_BITS-1:0] ula_b,
  output logic [2:0]          ula_ctrl,
  input  logic [ULA_BITS-1:0] ula_result,
  input  logic                ula_zero,
  input  logic                ula_carry,
  input  logic                ula_overflow,
  input  logic                ula_negative,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ULA_BITS-1:0] rsp_result,
  output logic                rsp_exec,
  output logic [3:0]          nzcv,
  output logic [CNT_W-1:0]    exec_cnt,
  output logic [CNT_W-1:0]    skip_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic                accept_s;
  logic                pass_r;
  logic                setf_r;
  logic [ULA_BITS-1:0] ula_a_r;
  logic [ULA_BITS-1:0] ula_b_r;
  logic [2:0]          ula_ctrl_r;
  logic [ULA_BITS-1:0] rsp_result_r;
  logic                rsp_exec_r;
  logic [3:0]          nzcv_r;
  logic [CNT_W-1:0]    exec_cnt_r;
  logic [CNT_W-1:0]    skip_cnt_r;

  // Flags are ordered {N,Z,C,V}; codes 14 and 15 both mean "always".
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'd0:    cond_pass = z;
      4'd1:    cond_pass = ~z;
      4'd2:    cond_pass = c;
      4'd3:    cond_pass = ~c;
      4'd4:    cond_pass = n;
      4'd5:    cond_pass = ~n;
      4'd6:    cond_pass = v;
      4'd7:    cond_pass = ~v;
      4'd8:    cond_pass = c & ~z;
      4'd9:    cond_pass = ~c | z;
      4'd10:   cond_pass = (n == v);
      4'd11:   cond_pass = (n != v);
      4'd12:   cond_pass = ~z & (n == v);
      4'd13:   cond_pass = z | (n != v);
      default: cond_pass = 1'b1;
    endcase
  endfunction

  assign cmd_ready  = (state_r == IDLE) | ((state_r == RESP) & rsp_ready);
  assign accept_s   = cmd_valid & cmd_ready;
  assign rsp_valid  = (state_r == RESP);
  assign ula_a      = ula_a_r;
  assign ula_b      = ula_b_r;
  assign ula_ctrl   = ula_ctrl_r;
  assign rsp_result = rsp_result_r;
  assign rsp_exec   = rsp_exec_r;
  assign nzcv       = nzcv_r;
  assign exec_cnt   = exec_cnt_r;
  assign skip_cnt   = skip_cnt_r;

  // Next-state logic; RESP can jump straight to EXEC when a new command is taken.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid) state_nxt_s = EXEC;
        else           state_nxt_s = IDLE;
      end
      EXEC: state_nxt_s = RESP;
      RESP: begin
        if (rsp_ready && cmd_valid) state_nxt_s = EXEC;
        else if (rsp_ready)         state_nxt_s = IDLE;
        else                        state_nxt_s = RESP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Command capture on accept; condition is judged against the flags as they stand now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ula_a_r    <= '0;
      ula_b_r    <= '0;
      ula_ctrl_r <= 3'b000;
      pass_r     <= 1'b0;
      setf_r     <= 1'b0;
    end else if (accept_s) begin
      ula_a_r    <= cmd_a;
      ula_b_r    <= cmd_b;
      ula_ctrl_r <= cmd_op;
      pass_r     <= cond_pass(cmd_cond, nzcv_r);
      setf_r     <= cmd_setf;
    end else begin
      ula_a_r    <= ula_a_r;
      ula_b_r    <= ula_b_r;
      ula_ctrl_r <= ula_ctrl_r;
      pass_r     <= pass_r;
      setf_r     <= setf_r;
    end
  end

  // Result, flag and counter update at the end of EXEC; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_r <= '0;
      rsp_exec_r   <= 1'b0;
      nzcv_r       <= 4'b0000;
      exec_cnt_r   <= '0;
      skip_cnt_r   <= '0;
    end else if (state_r == EXEC) begin
      rsp_result_r <= pass_r ? ula_result : '0;
      rsp_exec_r   <= pass_r;
      if (pass_r && setf_r) nzcv_r <= {ula_negative, ula_zero, ula_carry, ula_overflow};
      else                  nzcv_r <= nzcv_r;
      if (pass_r && (exec_cnt_r != '1))       exec_cnt_r <= exec_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      else                                    exec_cnt_r <= exec_cnt_r;
      if (!pass_r && (skip_cnt_r != '1))      skip_cnt_r <= skip_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      else                                    skip_cnt_r <= skip_cnt_r;
    end else begin
      rsp_result_r <= rsp_result_r;
      rsp_exec_r   <= rsp_exec_r;
      nzcv_r       <= nzcv_r;
      exec_cnt_r   <= exec_cnt_r;
      skip_cnt_r   <= skip_cnt_r;
    end
  end

endmodule
